// File: rtl/reaction_game_ctrl_if.sv
// Signal bundle between the reaction game round sequencer and its surroundings:
// tick, buttons and random source in; indicator, result and record out.
interface reaction_game_ctrl_if #(
    parameter int RAND_W = 11
);
    logic              tick_1ms;
    logic              btn_start;
    logic              btn_react;
    logic [RAND_W-1:0] rand_val;
    logic              led_go;
    logic              busy;
    logic [15:0]       result_ms;
    logic              result_valid;
    logic              false_start;
    logic              timeout;
    logic [15:0]       best_ms;

    modport master (
        output tick_1ms, btn_start, btn_react, rand_val,
        input  led_go, busy, result_ms, result_valid, false_start, timeout, best_ms
    );

    modport slave (
        input  tick_1ms, btn_start, btn_react, rand_val,
        output led_go, busy, result_ms, result_valid, false_start, timeout, best_ms
    );
endinterface

// File: rtl/reaction_game_ctrl.sv
// Round sequencer for the reaction speed game: randomised pre-GO delay,
// millisecond reaction timing, false-start/timeout detection and best-time record.
module reaction_game_ctrl #(
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_W       = 11,
    parameter int TIMEOUT_MS   = 9999
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reaction_game_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, DELAY, GO, DONE, FAULT} state_t;

    localparam logic [15:0] MIN_DELAY = 16'(MIN_DELAY_MS);
    localparam logic [15:0] TIMEOUT   = 16'(TIMEOUT_MS);
    localparam logic [15:0] LAST_MS   = 16'(TIMEOUT_MS - 1);

    state_t      state, state_n;
    logic [15:0] delay_cnt, delay_cnt_n;
    logic [15:0] ms_cnt, ms_cnt_n;
    logic [15:0] result_ms, result_ms_n;
    logic [15:0] best_ms, best_ms_n;
    logic        result_valid, result_valid_n;
    logic        false_start, false_start_n;
    logic        timeout, timeout_n;
    logic        led_go, led_go_n;
    logic        busy, busy_n;
    logic [RAND_W-1:0] rand_s;

    assign rand_s = bus.rand_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            delay_cnt    <= '0;
            ms_cnt       <= '0;
            result_ms    <= '0;
            best_ms      <= 16'hFFFF;
            result_valid <= 1'b0;
            false_start  <= 1'b0;
            timeout      <= 1'b0;
            led_go       <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            delay_cnt    <= delay_cnt_n;
            ms_cnt       <= ms_cnt_n;
            result_ms    <= result_ms_n;
            best_ms      <= best_ms_n;
            result_valid <= result_valid_n;
            false_start  <= false_start_n;
            timeout      <= timeout_n;
            led_go       <= led_go_n;
            busy         <= busy_n;
        end
    end

    always_comb begin
        state_n        = state;
        delay_cnt_n    = delay_cnt;
        ms_cnt_n       = ms_cnt;
        result_ms_n    = result_ms;
        best_ms_n      = best_ms;
        result_valid_n = 1'b0;
        false_start_n  = false_start;
        timeout_n      = timeout;

        case (state)
            IDLE, DONE, FAULT: begin
                if (bus.btn_start) begin
                    delay_cnt_n   = MIN_DELAY + 16'(rand_s);
                    result_ms_n   = '0;
                    false_start_n = 1'b0;
                    timeout_n     = 1'b0;
                    state_n       = DELAY;
                end
            end
            DELAY: begin
                // An early press beats an expiry tick arriving in the same cycle.
                if (bus.btn_react) begin
                    false_start_n = 1'b1;
                    state_n       = FAULT;
                end else if (bus.tick_1ms) begin
                    delay_cnt_n = delay_cnt - 16'd1;
                    if (delay_cnt == 16'd1) begin
                        ms_cnt_n = '0;
                        state_n  = GO;
                    end
                end
            end
            GO: begin
                if (bus.btn_react) begin
                    result_ms_n    = ms_cnt;
                    result_valid_n = 1'b1;
                    if (ms_cnt < best_ms) begin
                        best_ms_n = ms_cnt;
                    end
                    state_n = DONE;
                end else if (bus.tick_1ms) begin
                    if (ms_cnt == LAST_MS) begin
                        result_ms_n    = TIMEOUT;
                        timeout_n      = 1'b1;
                        result_valid_n = 1'b1;
                        state_n        = DONE;
                    end else begin
                        ms_cnt_n = ms_cnt + 16'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        led_go_n = (state_n == GO);
        busy_n   = (state_n == DELAY) || (state_n == GO);
    end

    assign bus.led_go       = led_go;
    assign bus.busy         = busy;
    assign bus.result_ms    = result_ms;
    assign bus.result_valid = result_valid;
    assign bus.false_start  = false_start;
    assign bus.timeout      = timeout;
    assign bus.best_ms      = best_ms;
endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Directed bench for reaction_game_ctrl with small parameters (4 ms min delay,
// 3-bit random part, 20 ms window) and a 1 ms tick every 10 clocks.
module tb_reaction_game_ctrl;
    localparam int MIN_DELAY_MS = 4;
    localparam int RAND_W       = 3;
    localparam int TIMEOUT_MS   = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   check_count = 0;
    int   error_count = 0;
    int   valid_count = 0;
    logic led_seen = 1'b0;

    reaction_game_ctrl_if #(.RAND_W(RAND_W)) bus ();

    reaction_game_ctrl #(
        .MIN_DELAY_MS(MIN_DELAY_MS),
        .RAND_W      (RAND_W),
        .TIMEOUT_MS  (TIMEOUT_MS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One clock: drive pulses, let the edge happen, sample 1 ns later.
    task automatic applyStimulus(input logic t, input logic s, input logic r);
        bus.tick_1ms  = t;
        bus.btn_start = s;
        bus.btn_react = r;
        @(posedge clk);
        #1;
        bus.tick_1ms  = 1'b0;
        bus.btn_start = 1'b0;
        bus.btn_react = 1'b0;
        if (bus.result_valid === 1'b1) valid_count++;
        if (bus.led_go === 1'b1) led_seen = 1'b1;
    endtask

    task automatic runMs(input int n, input logic react_on_last);
        for (int i = 0; i < n; i++) begin
            repeat (9) applyStimulus(1'b0, 1'b0, 1'b0);
            applyStimulus(1'b1, 1'b0, react_on_last && (i == n - 1));
        end
    endtask

    // Start a round, then scramble rand_val to prove it was sampled only once.
    task automatic pressStart(input logic [RAND_W-1:0] rv);
        bus.rand_val = rv;
        applyStimulus(1'b0, 1'b1, 1'b0);
        bus.rand_val = ~rv;
        valid_count = 0;
        led_seen    = 1'b0;
    endtask

    initial begin
        bus.tick_1ms  = 1'b0;
        bus.btn_start = 1'b0;
        bus.btn_react = 1'b0;
        bus.rand_val  = '0;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_led_go", 32'(bus.led_go), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_result_ms", 32'(bus.result_ms), 32'd0);
        checkOutput("rst_result_valid", 32'(bus.result_valid), 32'd0);
        checkOutput("rst_false_start", 32'(bus.false_start), 32'd0);
        checkOutput("rst_timeout", 32'(bus.timeout), 32'd0);
        checkOutput("rst_best_ms", 32'(bus.best_ms), 32'hFFFF);
        rst_n = 1'b1;
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);

        // Round 1: delay 4+3 = 7 ticks, react after 5 ticks in GO
        pressStart(3'd3);
        checkOutput("r1_busy", 32'(bus.busy), 32'd1);
        checkOutput("r1_led_early", 32'(bus.led_go), 32'd0);
        runMs(6, 1'b0);
        checkOutput("r1_led_6ticks", 32'(bus.led_go), 32'd0);
        runMs(1, 1'b0);
        checkOutput("r1_led_7ticks", 32'(bus.led_go), 32'd1);
        runMs(5, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("r1_result_ms", 32'(bus.result_ms), 32'd5);
        checkOutput("r1_result_valid", 32'(bus.result_valid), 32'd1);
        checkOutput("r1_best_ms", 32'(bus.best_ms), 32'd5);
        checkOutput("r1_timeout", 32'(bus.timeout), 32'd0);
        checkOutput("r1_led_off", 32'(bus.led_go), 32'd0);
        checkOutput("r1_busy_off", 32'(bus.busy), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("r1_valid_drop", 32'(bus.result_valid), 32'd0);
        checkOutput("r1_valid_pulses", 32'(valid_count), 32'd1);

        // Round 2: slower, best stays
        pressStart(3'd0);
        runMs(4, 1'b0);
        checkOutput("r2_led", 32'(bus.led_go), 32'd1);
        runMs(9, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("r2_result_ms", 32'(bus.result_ms), 32'd9);
        checkOutput("r2_best_ms", 32'(bus.best_ms), 32'd5);

        // Round 3: faster, new best
        pressStart(3'd1);
        runMs(5, 1'b0);
        checkOutput("r3_led", 32'(bus.led_go), 32'd1);
        runMs(2, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("r3_result_ms", 32'(bus.result_ms), 32'd2);
        checkOutput("r3_best_ms", 32'(bus.best_ms), 32'd2);

        // False start during an 11 ms delay
        pressStart(3'd7);
        runMs(3, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("fs_flag", 32'(bus.false_start), 32'd1);
        checkOutput("fs_busy", 32'(bus.busy), 32'd0);
        runMs(15, 1'b0);
        checkOutput("fs_led_never", 32'(led_seen), 32'd0);
        checkOutput("fs_no_valid", 32'(valid_count), 32'd0);
        checkOutput("fs_best_ms", 32'(bus.best_ms), 32'd2);
        checkOutput("fs_flag_sticky", 32'(bus.false_start), 32'd1);

        // Restart clears the flag; starts during DELAY and GO are ignored
        pressStart(3'd2);
        checkOutput("rs_flag_clear", 32'(bus.false_start), 32'd0);
        checkOutput("rs_busy", 32'(bus.busy), 32'd1);
        runMs(2, 1'b0);
        bus.rand_val = 3'd7;
        applyStimulus(1'b0, 1'b1, 1'b0);
        runMs(3, 1'b0);
        checkOutput("ig_led_5ticks", 32'(bus.led_go), 32'd0);
        runMs(1, 1'b0);
        checkOutput("ig_led_6ticks", 32'(bus.led_go), 32'd1);
        runMs(1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("ig_go_led", 32'(bus.led_go), 32'd1);
        runMs(2, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("ig_result_ms", 32'(bus.result_ms), 32'd3);
        checkOutput("ig_best_ms", 32'(bus.best_ms), 32'd2);

        // Timeout with no reaction
        pressStart(3'd0);
        runMs(4, 1'b0);
        runMs(19, 1'b0);
        checkOutput("to_still_go", 32'(bus.led_go), 32'd1);
        runMs(1, 1'b0);
        checkOutput("to_result_ms", 32'(bus.result_ms), 32'd20);
        checkOutput("to_flag", 32'(bus.timeout), 32'd1);
        checkOutput("to_valid", 32'(bus.result_valid), 32'd1);
        checkOutput("to_led_off", 32'(bus.led_go), 32'd0);
        checkOutput("to_best_ms", 32'(bus.best_ms), 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("to_valid_pulses", 32'(valid_count), 32'd1);

        // Reaction coincident with the timeout tick wins
        pressStart(3'd0);
        checkOutput("tr_timeout_clear", 32'(bus.timeout), 32'd0);
        runMs(4, 1'b0);
        runMs(19, 1'b0);
        runMs(1, 1'b1);
        checkOutput("tr_result_ms", 32'(bus.result_ms), 32'd19);
        checkOutput("tr_timeout", 32'(bus.timeout), 32'd0);
        checkOutput("tr_best_ms", 32'(bus.best_ms), 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("tr_valid_pulses", 32'(valid_count), 32'd1);

        // Reaction on the final DELAY tick is a false start
        pressStart(3'd0);
        runMs(3, 1'b0);
        runMs(1, 1'b1);
        checkOutput("fd_flag", 32'(bus.false_start), 32'd1);
        checkOutput("fd_led", 32'(bus.led_go), 32'd0);
        runMs(2, 1'b0);
        checkOutput("fd_led_never", 32'(led_seen), 32'd0);

        // Asynchronous reset in the middle of GO
        pressStart(3'd0);
        runMs(6, 1'b0);
        checkOutput("ar_led_before", 32'(bus.led_go), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("ar_led", 32'(bus.led_go), 32'd0);
        checkOutput("ar_busy", 32'(bus.busy), 32'd0);
        checkOutput("ar_best_ms", 32'(bus.best_ms), 32'hFFFF);
        @(negedge clk);
        rst_n = 1'b1;
        runMs(1, 1'b0);
        checkOutput("ar_idle_busy", 32'(bus.busy), 32'd0);
        checkOutput("ar_idle_led", 32'(bus.led_go), 32'd0);
        pressStart(3'd0);
        checkOutput("ar_restart_busy", 32'(bus.busy), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end
endmodule
